pla_tt_scanner: RTL and testbench
=================================

Name: pla_tt_scanner

Overview:
- Sequencer that drives an external combinational function-under-test (FUT, N_IN inputs, 1 output) through all 2^N_IN input vectors.
- Captures the FUT's truth table into an internal bitmap and counts on-set minterms.
- Then runs an autosymmetry check: for a programmable shift vector alpha, tests whether f(x) = f(x XOR alpha) holds for every x.
- Sits between the benchmark logic blocks and the results/readback logic; one scanner instance per FUT.

Parameters:
- N_IN, 8, width of FUT input vector; truth table holds 2^N_IN bits.
- FUT_LAT, 0, number of register stages between fut_x and fut_y (0 = purely combinational FUT).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new scan; accepted only in IDLE.
- alpha  input  N_IN  shift vector; latched on start accept.
- fut_x  output  N_IN  input vector driven to the FUT.
- fut_y  input  1  FUT output, valid FUT_LAT cycles after the matching fut_x.
- busy  output  1  high from the cycle after start accept through the done cycle inclusive.
- done  output  1  one-cycle pulse at end of check.
- onset_count  output  N_IN+1  number of captured 1s (0..2^N_IN).
- invariant  output  1  1 = f(x) equals f(x^alpha) for all x.
- tt_rd_addr  input  N_IN  truth-table readback address.
- tt_rd_data  output  1  combinational read of tt[tt_rd_addr].

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; fut_x=0, busy=0, done=0, onset_count=0, invariant=0.
  - Truth table cleared to all 0; alpha register 0; latency pipeline valids 0.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- States: IDLE -> SCAN -> DRAIN -> CHECK -> DONE -> IDLE.
- IDLE:
  - fut_x=0.
  - start=1 at a rising edge: latch alpha, clear onset_count to 0, set invariant=1, index=0, go to SCAN.
- SCAN: 2^N_IN cycles.
  - fut_x=index, index increments 0..2^N_IN-1.
  - Each cycle pushes (index, valid=1) into a FUT_LAT-deep delay line.
  - The delay-line output (for FUT_LAT=0, the current index) writes tt[addr_d] <= fut_y; onset_count increments when fut_y=1 and valid_d=1.
  - After index 2^N_IN-1: go to DRAIN (or directly to CHECK when FUT_LAT=0).
- DRAIN: exactly FUT_LAT cycles.
  - fut_x holds its last value; the delay line keeps capturing with valid=0 inputs.
  - Every one of the 2^N_IN vectors is captured exactly once.
- CHECK: 2^N_IN cycles, index i = 0..2^N_IN-1.
  - If tt[i] != tt[i XOR alpha], clear invariant. invariant is sticky-low until the next start.
  - alpha=0 always leaves invariant=1.
- DONE: one cycle; done=1, busy=1; next state IDLE.
- Timing:
  - Counting the cycle after start accept as cycle 1, done is high in cycle 2*2^N_IN + FUT_LAT + 1 (N_IN=8, FUT_LAT=0: cycle 513).
  - busy falls the following cycle.
- Result holding: onset_count, invariant and tt hold their values in IDLE until the next accepted start.
- start while busy: ignored, with no effect on any state or output.
- start asserted in the DONE cycle: ignored. Only an IDLE-state start is accepted.
- start held high continuously: a new scan is accepted on the first IDLE cycle after DONE.
- onset_count never wraps; it reaches at most 2^N_IN, which fits in N_IN+1 bits.
- tt_rd_data is a live read at all times. Contents are only meaningful when busy=0 after a completed scan.
- alpha input changes after accept have no effect on the current check.

Test Plan:
- Bench FUT = constant 0, alpha=0x00, start -> done in cycle 513; onset_count=0, invariant=1; tt_rd_data=0 at every address.
- FUT = x[0], alpha=0x02 -> onset_count=128, invariant=1. Rerun with alpha=0x01 -> invariant=0, onset_count=128. tt_rd_addr=0x01 gives 1; 0x02 gives 0.
- FUT = AND of all 8 bits, alpha=0xFF -> onset_count=1, invariant=0; tt_rd_data at 0xFF = 1, at 0xFE = 0.
- FUT_LAT=2 build, FUT = registered x[7] (2 stages), alpha=0x7F -> done in cycle 515; onset_count=128, invariant=1; tt[0x80]=1, tt[0x7F]=0. No capture misaligned by the pipeline.
- start pulsed again at cycle 200 of a scan -> ignored; results and done timing are identical to an undisturbed run.
- rst_n driven low at cycle 100 of SCAN -> same cycle: busy=0, onset_count=0, invariant=0, all tt bits 0, no done pulse. A fresh start after release completes normally.

Source files
------------

// File: rtl/pla_tt_scanner_if.sv
// -----------------------------------------------------------------------------
// pla_tt_scanner_if
// Control and readback bundle between a host (master) and one truth-table
// scanner (slave).
//
// Signals:
//   start        host -> scanner  request a new scan
//   alpha        host -> scanner  autosymmetry shift vector, sampled on accept
//   tt_rd_addr   host -> scanner  truth-table readback address
//   busy         scanner -> host  scan/check in progress (includes done cycle)
//   done         scanner -> host  one-cycle end-of-check pulse
//   onset_count  scanner -> host  number of 1s captured from the FUT
//   invariant    scanner -> host  1 = f(x) == f(x ^ alpha) for every x
//   tt_rd_data   scanner -> host  live read of tt[tt_rd_addr]
//
// Handshake: start acts as a request and busy as its inverse ready. A request
// is accepted on any rising edge where start=1 and busy=0; alpha is sampled on
// that same edge. While busy=1 start is ignored. Holding start high simply
// re-requests, so a new scan starts on the first idle cycle after done.
// -----------------------------------------------------------------------------
interface pla_tt_scanner_if #(
  parameter int N_IN = 8
);
  logic            start;
  logic [N_IN-1:0] alpha;
  logic [N_IN-1:0] tt_rd_addr;
  logic            busy;
  logic            done;
  logic [N_IN:0]   onset_count;
  logic            invariant;
  logic            tt_rd_data;

  modport master (
    output start, alpha, tt_rd_addr,
    input  busy, done, onset_count, invariant, tt_rd_data
  );

  modport slave (
    input  start, alpha, tt_rd_addr,
    output busy, done, onset_count, invariant, tt_rd_data
  );
endinterface

// File: rtl/pla_tt_scanner.sv
// -----------------------------------------------------------------------------
// pla_tt_scanner
// Walks an external combinational (or FUT_LAT-pipelined) function through all
// 2^N_IN input vectors, captures its truth table, counts the on-set and then
// checks autosymmetry f(x) == f(x ^ alpha) over the captured table.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   ctl         control/readback bundle (slave side), see pla_tt_scanner_if
//   fut_x       vector driven to the function under test
//   fut_y       FUT response, valid FUT_LAT cycles after its fut_x
//   dbg_state   current FSM state encoding
// -----------------------------------------------------------------------------
module pla_tt_scanner #(
  parameter int N_IN    = 8,
  parameter int FUT_LAT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  pla_tt_scanner_if.slave ctl,
  output logic [N_IN-1:0] fut_x,
  input  logic            fut_y,
  output logic [2:0]      dbg_state
);

  localparam int DEPTH = 1 << N_IN;
  localparam logic [N_IN-1:0] IDX_LAST = '1;
  localparam logic [N_IN-1:0] IDX_ONE  = 1;
  localparam logic [N_IN:0]   CNT_ONE  = 1;
  // Last drain index; DRAIN is never entered when FUT_LAT is 0.
  localparam logic [N_IN-1:0] DRAIN_LAST = (FUT_LAT > 0) ? N_IN'(FUT_LAT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_DRAIN = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [N_IN-1:0]   idx;
  logic [N_IN-1:0]   alpha_q;
  logic [DEPTH-1:0]  tt;
  logic [N_IN:0]     onset_q;
  logic              inv_q;
  logic              busy, done, accept;
  logic [N_IN-1:0]   cap_addr;
  logic              cap_vld;

  assign accept          = (state == S_IDLE) && ctl.start;
  assign dbg_state       = state;
  assign ctl.busy        = busy;
  assign ctl.done        = done;
  assign ctl.onset_count = onset_q;
  assign ctl.invariant   = inv_q;
  assign ctl.tt_rd_data  = tt[ctl.tt_rd_addr];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and FSM outputs. idx is shared: scan index, drain count and
  // check index, and it wraps to 0 at the end of each phase.
  always_comb begin
    state_nxt = state;
    fut_x     = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (ctl.start) state_nxt = S_SCAN;
      end
      S_SCAN: begin
        fut_x = idx;
        if (idx == IDX_LAST) state_nxt = (FUT_LAT == 0) ? S_CHECK : S_DRAIN;
      end
      S_DRAIN: begin
        fut_x = IDX_LAST;
        if (idx == DRAIN_LAST) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        fut_x = IDX_LAST;
        if (idx == IDX_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        fut_x     = IDX_LAST;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture alignment: the address that produced the current fut_y is the
  // scan index delayed by FUT_LAT cycles, tagged valid only for SCAN pushes.
  generate
    if (FUT_LAT == 0) begin : g_no_lat
      assign cap_addr = idx;
      assign cap_vld  = (state == S_SCAN);
    end else begin : g_lat
      logic [N_IN-1:0]    pipe_addr [FUT_LAT];
      logic [FUT_LAT-1:0] pipe_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < FUT_LAT; k++) pipe_addr[k] <= '0;
          pipe_vld <= '0;
        end else begin
          pipe_addr[0] <= idx;
          pipe_vld[0]  <= (state == S_SCAN);
          for (int k = 1; k < FUT_LAT; k++) begin
            pipe_addr[k] <= pipe_addr[k-1];
            pipe_vld[k]  <= pipe_vld[k-1];
          end
        end
      end

      assign cap_addr = pipe_addr[FUT_LAT-1];
      assign cap_vld  = pipe_vld[FUT_LAT-1];
    end
  endgenerate

  // Datapath: index, latched alpha, truth table and results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      alpha_q <= '0;
      tt      <= '0;
      onset_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      if (accept) begin
        alpha_q <= ctl.alpha;
        onset_q <= '0;
        inv_q   <= 1'b1;
        idx     <= '0;
      end
      case (state)
        S_SCAN:  idx <= idx + IDX_ONE;
        S_DRAIN: idx <= (idx == DRAIN_LAST) ? '0 : idx + IDX_ONE;
        S_CHECK: begin
          // Sticky clear: one asymmetric pair is enough to fail the check.
          if (tt[idx] != tt[idx ^ alpha_q]) inv_q <= 1'b0;
          idx <= idx + IDX_ONE;
        end
        default: ;
      endcase
      if (cap_vld) begin
        tt[cap_addr] <= fut_y;
        if (fut_y) onset_q <= onset_q + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pla_tt_scanner.sv
// -----------------------------------------------------------------------------
// tb_pla_tt_scanner
// Two scanners: u_dut0 (FUT_LAT=0) driven by a lookup-table FUT, and u_dut2
// (FUT_LAT=2) driven by a two-stage registered x[7]. Expected results come
// from fixed vectors and from a reference model over ref_tbl.
// -----------------------------------------------------------------------------
module tb_pla_tt_scanner;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and FUTs ----------------
  pla_tt_scanner_if #(.N_IN(8)) if0 ();
  pla_tt_scanner_if #(.N_IN(8)) if2 ();

  logic [7:0] fut_x0, fut_x2;
  logic       fut_y0, fut_y2;
  logic [2:0] dbg0, dbg2;
  logic       r1 = 1'b0;
  logic       r2 = 1'b0;

  bit fut_tbl [256];
  bit ref_tbl [256];

  assign fut_y0 = fut_tbl[fut_x0];
  always @(posedge clk) begin
    r1 <= fut_x2[7];
    r2 <= r1;
  end
  assign fut_y2 = r2;

  pla_tt_scanner #(.N_IN(8), .FUT_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ctl(if0),
    .fut_x(fut_x0), .fut_y(fut_y0), .dbg_state(dbg0)
  );

  pla_tt_scanner #(.N_IN(8), .FUT_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ctl(if2),
    .fut_x(fut_x2), .fut_y(fut_y2), .dbg_state(dbg2)
  );

  // Selected DUT view for the shared tasks
  int cur = 0;
  wire       cur_busy  = (cur == 2) ? if2.busy        : if0.busy;
  wire       cur_done  = (cur == 2) ? if2.done        : if0.done;
  wire [8:0] cur_onset = (cur == 2) ? if2.onset_count : if0.onset_count;
  wire       cur_inv   = (cur == 2) ? if2.invariant   : if0.invariant;
  wire       cur_rd    = (cur == 2) ? if2.tt_rd_data  : if0.tt_rd_data;

  // ---------------- scoreboard ----------------
  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_onset();
    int n = 0;
    for (int x = 0; x < 256; x++) n += int'(ref_tbl[x]);
    return n;
  endfunction

  function automatic bit ref_inv(input logic [7:0] a);
    for (int x = 0; x < 256; x++)
      if (ref_tbl[x] != ref_tbl[x ^ int'(a)]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input int sel, input bit s, input logic [7:0] a);
    if (sel == 2) begin
      if2.start = s;
      if2.alpha = a;
    end else begin
      if0.start = s;
      if0.alpha = a;
    end
  endtask

  task automatic fill_mode(input int m);
    for (int x = 0; x < 256; x++)
      case (m)
        1:       fut_tbl[x] = (x % 2) == 1;
        2:       fut_tbl[x] = (x == 255);
        default: fut_tbl[x] = 1'b0;
      endcase
  endtask

  task automatic rd_at(input logic [7:0] a, output bit v);
    if0.tt_rd_addr = a;
    if2.tt_rd_addr = a;
    #1;
    v = cur_rd;
  endtask

  task automatic chk_tt(input string name);
    int bad = 0;
    bit v;
    for (int a = 0; a < 256; a++) begin
      rd_at(8'(a), v);
      if (v !== ref_tbl[a]) bad++;
    end
    chk(name, bad, 0);
  endtask

  task automatic wait_done(input string tag, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 1500 && !seen; k++) begin
      @(negedge clk);
      if (cur_done) seen = 1'b1;
    end
    if (!seen) begin
      nchk++;
      nerr++;
      $display("FAIL %s_timeout: got no done, required done within 1500 cycles", tag);
    end
  endtask

  // One scan on DUT sel. poke>0 re-pulses start (with another alpha) at that
  // cycle; hold keeps start high through the run to test re-acceptance.
  task automatic run_scan(input string tag, input int sel, input logic [7:0] a,
                          input int poke, input bit hold);
    int k;
    bit seen;
    int exp_done;
    exp_done = 2 * 256 + ((sel == 2) ? 2 : 0) + 1;
    cur = sel;
    @(negedge clk);
    drive(sel, 1'b1, a);
    @(negedge clk);                       // cycle 1 after accept
    chk({tag, "_busy_c1"}, cur_busy, 1);
    if (!hold) drive(sel, 1'b0, ~a);      // alpha moves after accept
    k = 1;
    seen = 1'b0;
    while (!seen && k <= 1500) begin
      if (cur_done) seen = 1'b1;
      else begin
        if (poke > 0 && k == poke)     drive(sel, 1'b1, a ^ 8'h01);
        if (poke > 0 && k == poke + 1) drive(sel, 1'b0, ~a);
        @(negedge clk);
        k++;
      end
    end
    if (!seen) begin
      nchk++;
      nerr++;
      $display("FAIL %s_done_timeout: got no done, required done at cycle %0d", tag, exp_done);
      return;
    end
    chk({tag, "_done_cycle"}, k, exp_done);
    chk({tag, "_busy_at_done"}, cur_busy, 1);
    @(negedge clk);
    chk({tag, "_done_width"}, cur_done, 0);
    chk({tag, "_busy_fall"}, cur_busy, 0);
    if (hold) begin
      @(negedge clk);
      chk({tag, "_reaccept"}, cur_busy, 1);
      drive(sel, 1'b0, a);
      wait_done({tag, "_second"}, seen);
      @(negedge clk);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int         mode;       // 0: const 0, 1: x[0], 2: AND of all bits
    logic [7:0] alpha;
    int         exp_onset;
    bit         exp_inv;
    logic [7:0] a1;
    bit         e1;
    logic [7:0] a2;
    bit         e2;
  } vec_t;

  vec_t vecs [4];

  initial begin
    bit v;
    bit seen;
    int dcount;
    logic [7:0] ra;

    vecs[0] = '{0, 8'h00,   0, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[1] = '{1, 8'h02, 128, 1'b1, 8'h01, 1'b1, 8'h02, 1'b0};
    vecs[2] = '{1, 8'h01, 128, 1'b0, 8'h01, 1'b1, 8'h02, 1'b0};
    vecs[3] = '{2, 8'hFF,   1, 1'b0, 8'hFF, 1'b1, 8'hFE, 1'b0};

    drive(0, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    if0.tt_rd_addr = 8'h00;
    if2.tt_rd_addr = 8'h00;
    fill_mode(0);

    // Reset state
    #1;
    chk("rst_busy0",  if0.busy, 0);
    chk("rst_done0",  if0.done, 0);
    chk("rst_onset0", if0.onset_count, 0);
    chk("rst_inv0",   if0.invariant, 0);
    chk("rst_futx0",  fut_x0, 0);
    chk("rst_state0", dbg0, 0);
    chk("rst_busy2",  if2.busy, 0);
    chk("rst_inv2",   if2.invariant, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven scans on the zero-latency scanner
    for (int i = 0; i < 4; i++) begin
      fill_mode(vecs[i].mode);
      ref_tbl = fut_tbl;
      run_scan($sformatf("vec%0d", i), 0, vecs[i].alpha, 0, 1'b0);
      chk($sformatf("vec%0d_onset", i), cur_onset, vecs[i].exp_onset);
      chk($sformatf("vec%0d_inv", i),   cur_inv,   vecs[i].exp_inv);
      rd_at(vecs[i].a1, v);
      chk($sformatf("vec%0d_rd_a1", i), v, vecs[i].e1);
      rd_at(vecs[i].a2, v);
      chk($sformatf("vec%0d_rd_a2", i), v, vecs[i].e2);
      chk_tt($sformatf("vec%0d_tt", i));
    end

    // Two-stage pipelined FUT: x[7]
    for (int x = 0; x < 256; x++) ref_tbl[x] = (x >= 128);
    run_scan("lat2", 2, 8'h7F, 0, 1'b0);
    chk("lat2_onset", cur_onset, 128);
    chk("lat2_inv",   cur_inv, 1);
    rd_at(8'h80, v);
    chk("lat2_rd_80", v, 1);
    rd_at(8'h7F, v);
    chk("lat2_rd_7f", v, 0);
    chk_tt("lat2_tt");

    // start re-pulsed at cycle 200 while busy
    fill_mode(1);
    ref_tbl = fut_tbl;
    run_scan("poke", 0, 8'h01, 200, 1'b0);
    chk("poke_onset", cur_onset, 128);
    chk("poke_inv",   cur_inv, 0);

    // start held high through done: ignored in DONE, taken in next IDLE
    fill_mode(2);
    ref_tbl = fut_tbl;
    run_scan("hold", 0, 8'hFF, 0, 1'b1);
    chk("hold_onset", cur_onset, 1);
    chk("hold_inv",   cur_inv, 0);

    // Randomized FUTs against the reference model
    for (int it = 0; it < 6; it++) begin
      ra = 8'($urandom_range(0, 255));
      for (int x = 0; x < 256; x++) fut_tbl[x] = ($urandom_range(0, 1) == 1);
      if (it % 2 == 1)
        for (int x = 0; x < 256; x++)
          if (x < (x ^ int'(ra))) fut_tbl[x ^ int'(ra)] = fut_tbl[x];
      ref_tbl = fut_tbl;
      run_scan($sformatf("rnd%0d", it), 0, ra, 0, 1'b0);
      chk($sformatf("rnd%0d_onset", it), cur_onset, ref_onset());
      chk($sformatf("rnd%0d_inv", it),   cur_inv,   ref_inv(ra));
      chk_tt($sformatf("rnd%0d_tt", it));
    end

    // Reset at cycle 100 of SCAN
    fill_mode(1);
    cur = 0;
    @(negedge clk);
    drive(0, 1'b1, 8'h02);
    @(negedge clk);
    drive(0, 1'b0, 8'h02);
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  if0.busy, 0);
    chk("mid_rst_onset", if0.onset_count, 0);
    chk("mid_rst_inv",   if0.invariant, 0);
    chk("mid_rst_state", dbg0, 0);
    for (int x = 0; x < 256; x++) ref_tbl[x] = 1'b0;
    chk_tt("mid_rst_tt");
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (if0.done || if0.busy) dcount++;
    end
    chk("mid_rst_no_done", dcount, 0);

    // Fresh scan after the reset
    ref_tbl = fut_tbl;
    run_scan("post_rst", 0, 8'h02, 0, 1'b0);
    chk("post_rst_onset", cur_onset, 128);
    chk("post_rst_inv",   cur_inv, 1);
    chk_tt("post_rst_tt");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
